// File: rtl/bm_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock, valid/ready on both sides.
// Optional macro BM_OPS_CNT_EN adds OPS_CNT, the count of add/sub steps behind the current OUT.
module bm_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     Q_IN,
  input  logic [WIDTH-1:0]     N_IN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   OUT,
`ifdef BM_OPS_CNT_EN
  output logic [$clog2(WIDTH+1)-1:0] OPS_CNT,
`endif
  output logic                 BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef BM_OPS_CNT_EN
  localparam int OW = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic             q0_r;
  logic [WIDTH-1:0] n_r;
  logic [CW-1:0]    cnt_r;
`ifdef BM_OPS_CNT_EN
  logic [OW-1:0]    ops_r;
`endif

  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             is_op;

  // One Booth step: q_r shifts right each cycle, so q_r[0] is always the original bit i.
  always_comb begin
    n_ext = {n_r[WIDTH-1], n_r};
    sum   = a_r;
    is_op = 1'b0;
    case ({q_r[0], q0_r})
      2'b10: begin
        sum   = a_r - n_ext;
        is_op = 1'b1;
      end
      2'b01: begin
        sum   = a_r + n_ext;
        is_op = 1'b1;
      end
      default: begin
        sum   = a_r;
        is_op = 1'b0;
      end
    endcase
    a_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next = {sum[0], q_r[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      a_r       <= '0;
      q_r       <= '0;
      q0_r      <= 1'b0;
      n_r       <= '0;
      cnt_r     <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      IN_READY  <= 1'b1;
      BUSY      <= 1'b0;
`ifdef BM_OPS_CNT_EN
      ops_r     <= '0;
      OPS_CNT   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID) begin
            q_r      <= Q_IN;
            n_r      <= N_IN;
            a_r      <= '0;
            q0_r     <= 1'b0;
            cnt_r    <= '0;
            IN_READY <= 1'b0;
            BUSY     <= 1'b1;
            state_r  <= CALC;
`ifdef BM_OPS_CNT_EN
            ops_r    <= '0;
`endif
          end
        end
        CALC: begin
          a_r  <= a_next;
          q_r  <= q_next;
          q0_r <= q_r[0];
`ifdef BM_OPS_CNT_EN
          ops_r <= ops_r + OW'(is_op);
`endif
          if (cnt_r == LAST) begin
            OUT       <= {a_next[WIDTH-1:0], q_next};
            OUT_VALID <= 1'b1;
            state_r   <= HOLD;
`ifdef BM_OPS_CNT_EN
            OPS_CNT   <= ops_r + OW'(is_op);
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            BUSY      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          OUT_VALID <= 1'b0;
          IN_READY  <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bm_seq_ctrl.sv
// Self-checking bench for bm_seq_ctrl: directed corners plus exhaustive WIDTH=4 and random WIDTH=8 runs.
module tb_bm_seq_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST_N;
  logic       iv4, ir4, ov4, or4, busy4;
  logic [3:0] q4, n4;
  logic [7:0] out4;
  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] q8, n8;
  logic [15:0] out8;
`ifdef BM_OPS_CNT_EN
  logic [2:0] ops4;
  logic [3:0] ops8;
`endif

  int errors = 0;
  int checks = 0;

  bm_seq_ctrl #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv4), .IN_READY(ir4),
    .Q_IN(q4), .N_IN(n4), .OUT_VALID(ov4), .OUT_READY(or4),
    .OUT(out4),
`ifdef BM_OPS_CNT_EN
    .OPS_CNT(ops4),
`endif
    .BUSY(busy4)
  );

  bm_seq_ctrl #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv8), .IN_READY(ir8),
    .Q_IN(q8), .N_IN(n8), .OUT_VALID(ov8), .OUT_READY(or8),
    .OUT(out8),
`ifdef BM_OPS_CNT_EN
    .OPS_CNT(ops8),
`endif
    .BUSY(busy8)
  );

  // Booth rule: an add/sub happens at bit i whenever q[i] differs from q[i-1] (q[-1] = 0).
  function automatic int booth_ops(input logic [31:0] q, input int w);
    int   c;
    logic prev;
    c = 0;
    prev = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (q[i] !== prev) c++;
      prev = q[i];
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one WIDTH=4 transaction; lat is -1 if OUT_VALID never arrives.
  task automatic op4(input logic [3:0] q, input logic [3:0] n, input int stall,
                     output logic [7:0] res, output int lat, output int ops);
    int w;
    w = 0;
    while (!ir4 && w < 20) begin tick(); w++; end
    iv4 = 1'b1; q4 = q; n4 = n;
    tick();
    iv4 = 1'b0; q4 = 4'($urandom); n4 = 4'($urandom);
    lat = 0;
    while (!ov4 && lat < 20) begin tick(); lat++; end
    if (!ov4) lat = -1;
    repeat (stall) tick();
    res = out4;
`ifdef BM_OPS_CNT_EN
    ops = int'(ops4);
`else
    ops = 0;
`endif
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] q, input logic [7:0] n, input int stall,
                     output logic [15:0] res, output int lat, output logic vld, output int ops);
    int w;
    w = 0;
    while (!ir8 && w < 20) begin tick(); w++; end
    iv8 = 1'b1; q8 = q; n8 = n;
    tick();
    iv8 = 1'b0; q8 = 8'($urandom); n8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 30) begin tick(); lat++; end
    if (!ov8) lat = -1;
    repeat (stall) tick();
    res = out8;
    vld = ov8;
`ifdef BM_OPS_CNT_EN
    ops = int'(ops8);
`else
    ops = 0;
`endif
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    checks++; if (out4 !== 8'h00) begin errors++; $display("FAIL reset_out4: got %h want 00", out4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", ov4); end
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b want 1", ir4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    checks++; if (out8 !== 16'h0000) begin errors++; $display("FAIL reset_out8: got %h want 0000", out8); end
    checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL reset_ctl8: got ready=%b valid=%b busy=%b want 1 0 0", ir8, ov8, busy8);
    end
`ifdef BM_OPS_CNT_EN
    checks++; if (ops4 !== 3'd0) begin errors++; $display("FAIL reset_ops4: got %0d want 0", ops4); end
`endif
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] res;
    int lat, ops;
    op4(4'd7, 4'd5, 0, res, lat, ops);
    checks++; if (res !== 8'h23) begin errors++; $display("FAIL basic_prod: got %h want 23", res); end
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
`ifdef BM_OPS_CNT_EN
    checks++; if (ops != 2) begin errors++; $display("FAIL basic_ops: got %0d want 2", ops); end
`endif
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL basic_release: got valid=%b ready=%b want 0 1", ov4, ir4);
    end
    checks++; if (out4 !== 8'h23) begin errors++; $display("FAIL basic_out_kept: got %h want 23", out4); end
  endtask

  task automatic test_corners();
    logic [3:0] tq [3];
    logic [3:0] tn [3];
    logic [7:0] te [3];
    logic [7:0] res;
    int lat, ops;
    tq[0] = 4'h8; tn[0] = 4'h8; te[0] = 8'h40;
    tq[1] = 4'h8; tn[1] = 4'h7; te[1] = 8'hC8;
    tq[2] = 4'h3; tn[2] = 4'hE; te[2] = 8'hFA;
    for (int i = 0; i < 3; i++) begin
      op4(tq[i], tn[i], 1, res, lat, ops);
      checks++; if (res !== te[i]) begin
        errors++; $display("FAIL corner_%0d: got %h want %h", i, res, te[i]);
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL corner_lat_%0d: got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int w, lat;
    iv4 = 1'b1; q4 = 4'd2; n4 = 4'd3;
    tick();
    iv4 = 1'b0;
    w = 0;
    while (!ov4 && w < 20) begin tick(); w++; end
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL bp_reach_hold: got valid=%b want 1", ov4); end
    iv4 = 1'b1; q4 = 4'd5; n4 = 4'hD;
    or4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (ov4 !== 1'b1 || out4 !== 8'h06 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b out=%h ready=%b want 1 06 0", i, ov4, out4, ir4);
      end
    end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL bp_to_idle: got valid=%b ready=%b want 0 1", ov4, ir4);
    end
    tick();
    iv4 = 1'b0;
    checks++; if (ir4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got ready=%b busy=%b want 0 1", ir4, busy4);
    end
    lat = 0;
    while (!ov4 && lat < 20) begin tick(); lat++; end
    checks++; if (lat != 4 || out4 !== 8'hF1) begin
      errors++; $display("FAIL bp_new_prod: got lat=%0d out=%h want 4 f1", lat, out4);
    end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat, ops;
    logic seen;
    iv4 = 1'b1; q4 = 4'd7; n4 = 4'd7;
    tick();
    iv4 = 1'b0;
    tick();
    RST_N = 1'b0;
    tick();
    checks++; if (ir4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl: got ready=%b busy=%b valid=%b want 1 0 0", ir4, busy4, ov4);
    end
    checks++; if (out4 !== 8'h00) begin errors++; $display("FAIL midrst_out: got %h want 00", out4); end
    RST_N = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); if (ov4 !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse: got pulse=%b want 0", seen); end
    op4(4'd7, 4'd7, 0, res, lat, ops);
    checks++; if (res !== 8'h31 || lat != 4) begin
      errors++; $display("FAIL midrst_after: got out=%h lat=%0d want 31 4", res, lat);
    end
  endtask

  task automatic test_exhaustive4();
    logic signed [3:0] qs, ns;
    logic [7:0] res;
    int p, lat, ops;
    for (int qi = 0; qi < 16; qi++) begin
      for (int ni = 0; ni < 16; ni++) begin
        qs = 4'(qi);
        ns = 4'(ni);
        p = qs * ns;
        op4(qs, ns, 0, res, lat, ops);
        checks++; if (res !== 8'(p) || lat != 4) begin
          errors++; $display("FAIL exh4 %0d*%0d: got out=%h lat=%0d want %h 4", qs, ns, res, lat, 8'(p));
        end
`ifdef BM_OPS_CNT_EN
        checks++; if (ops != booth_ops(32'(qs), 4)) begin
          errors++; $display("FAIL exh4_ops %0d: got %0d want %0d", qs, ops, booth_ops(32'(qs), 4));
        end
`endif
      end
    end
  endtask

  task automatic test_random8();
    logic signed [7:0] qs, ns;
    logic [15:0] res;
    logic vld;
    int p, lat, ops, stall;
    for (int i = 0; i < 4000; i++) begin
      qs = 8'($urandom);
      ns = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      p = qs * ns;
      op8(qs, ns, stall, res, lat, vld, ops);
      checks++; if (res !== 16'(p) || lat != 8 || vld !== 1'b1) begin
        errors++;
        $display("FAIL rnd8 %0d*%0d: got out=%h lat=%0d valid=%b want %h 8 1", qs, ns, res, lat, vld, 16'(p));
      end
`ifdef BM_OPS_CNT_EN
      checks++; if (ops != booth_ops(32'(qs), 8)) begin
        errors++; $display("FAIL rnd8_ops %0d: got %0d want %0d", qs, ops, booth_ops(32'(qs), 8));
      end
`endif
    end
  endtask

  initial begin
    RST_N = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; q4 = 4'd0; n4 = 4'd0;
    iv8 = 1'b0; or8 = 1'b0; q8 = 8'd0; n8 = 8'd0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_exhaustive4();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
